// File: rtl/program_sequencer_if.sv
// Program load port between a byte source (master) and the program sequencer (slave).
// A byte transfers on every rising edge where load_valid and load_ready are both high;
// load_data and load_last must be stable while load_valid is high.
interface program_sequencer_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/program_sequencer.sv
// Instruction-side sequencer: stores a streamed program, then issues one opcode per
// clock to the control unit while tracking the PC from the control unit's decisions.
module program_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                reset,
  program_sequencer_if.slave  load,
  input  logic                run,
  input  logic                write_pc_CU,
  input  logic                PC_sel_CU,
  output logic [7:0]          opcode,
  output logic [ADDR_W-1:0]   pc,
  output logic                running,
  output logic [ADDR_W:0]     prog_len,
  output logic [15:0]         instr_count,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic              load_ready_q;
  logic              beat;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   pc_inc;

  assign load.load_ready = load_ready_q;
  assign beat            = load.load_valid & load_ready_q;
  // A load always restarts at address 0, whatever wr_ptr was left at.
  assign wr_addr         = (state == IDLE) ? '0 : wr_ptr;
  assign pc_inc          = {1'b0, pc} + (ADDR_W + 1)'(1);
  assign opcode          = running ? mem[pc] : 8'h00;
  assign dbg_state       = state;

  // Program memory survives reset on purpose; only the bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (!reset && beat) begin
      mem[wr_addr] <= load.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= '0;
      wr_ptr       <= '0;
      prog_len     <= '0;
      instr_count  <= '0;
      running      <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load_ready_q <= 1'b1;
          if (beat) begin
            wr_ptr <= ADDR_W'(1);
            if (load.load_last) begin
              prog_len <= (ADDR_W + 1)'(1);
            end else begin
              state <= LOAD;
            end
          end else if (run && (prog_len != '0)) begin
            state        <= RUN;
            running      <= 1'b1;
            load_ready_q <= 1'b0;
            pc           <= '0;
            instr_count  <= '0;
          end
        end

        LOAD: begin
          load_ready_q <= 1'b1;
          if (beat) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            // The last memory slot terminates the load even without load_last.
            if (load.load_last || (wr_ptr == LAST_ADDR)) begin
              state    <= IDLE;
              prog_len <= {1'b0, wr_ptr} + (ADDR_W + 1)'(1);
            end
          end
        end

        RUN: begin
          if (instr_count != 16'hFFFF) begin
            instr_count <= instr_count + 16'd1;
          end
          if (!run) begin
            state        <= IDLE;
            running      <= 1'b0;
            load_ready_q <= 1'b1;
            pc           <= '0;
          end else if (write_pc_CU) begin
            if (PC_sel_CU) begin
              pc <= opcode[ADDR_W-1:0];
            end else if (pc_inc >= prog_len) begin
              pc <= '0;
            end else begin
              pc <= pc_inc[ADDR_W-1:0];
            end
          end
        end

        default: begin
          state        <= IDLE;
          running      <= 1'b0;
          load_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: table of per-cycle vectors for load/run/jump/hold,
// then hand-written sequences for reset, empty-program run, full-depth load and mid-run reset.
module tb_program_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        write_pc_CU;
  logic        PC_sel_CU;
  logic [7:0]  opcode;
  logic [3:0]  pc;
  logic        running;
  logic [4:0]  prog_len;
  logic [15:0] instr_count;
  logic [1:0]  dbg_state;

  int pass_cnt;
  int total_cnt;

  program_sequencer_if lif ();

  program_sequencer #(.ADDR_W(4), .DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (lif),
    .run         (run),
    .write_pc_CU (write_pc_CU),
    .PC_sel_CU   (PC_sel_CU),
    .opcode      (opcode),
    .pc          (pc),
    .running     (running),
    .prog_len    (prog_len),
    .instr_count (instr_count),
    .dbg_state   (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        lv;
    logic [7:0]  ld;
    logic        ll;
    logic        r;
    logic        w;
    logic        s;
    logic        e_ready;
    logic        e_running;
    logic [3:0]  e_pc;
    logic [7:0]  e_op;
    logic [4:0]  e_plen;
    logic [15:0] e_icnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit lv, input logic [7:0] ld, input bit ll, input bit r,
                              input bit w, input bit s, input bit e_ready, input bit e_running,
                              input int e_pc, input logic [7:0] e_op, input int e_plen,
                              input int e_icnt);
    vec_t v;
    v.lv = lv; v.ld = ld; v.ll = ll; v.r = r; v.w = w; v.s = s;
    v.e_ready = e_ready; v.e_running = e_running;
    v.e_pc = 4'(e_pc); v.e_op = e_op; v.e_plen = 5'(e_plen); v.e_icnt = 16'(e_icnt);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit lv, input logic [7:0] ld, input bit ll, input bit r,
                       input bit w, input bit s);
    lif.load_valid = lv;
    lif.load_data  = ld;
    lif.load_last  = ll;
    run            = r;
    write_pc_CU    = w;
    PC_sel_CU      = s;
  endtask

  task automatic check_outs(input string tag, input bit e_ready, input bit e_running,
                            input int e_pc, input logic [7:0] e_op, input int e_plen);
    check({tag, " load_ready"}, 32'(lif.load_ready), 32'(e_ready));
    check({tag, " running"},    32'(running),        32'(e_running));
    check({tag, " pc"},         32'(pc),             32'(e_pc));
    check({tag, " opcode"},     32'(opcode),         32'(e_op));
    check({tag, " prog_len"},   32'(prog_len),       32'(e_plen));
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 0);

    //            lv ld     ll r  w  s   rdy run pc op     plen icnt
    vecs.push_back(mk(1, 8'h43, 0, 0, 0, 0,  1, 0,  0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h60, 0, 0, 0, 0,  1, 0,  0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h41, 0, 0, 0, 0,  1, 0,  0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'hA0, 1, 0, 0, 0,  1, 0,  0, 8'h00, 4, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0,  0, 1,  0, 8'h43, 4, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0,  0, 1,  1, 8'h60, 4, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0,  0, 1,  2, 8'h41, 4, 2));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0,  0, 1,  3, 8'hA0, 4, 3));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0,  0, 1,  0, 8'h43, 4, 4));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 0,  0, 8'h00, 4, 5));
    // run together with the first beat: the load wins
    vecs.push_back(mk(1, 8'h40, 0, 1, 0, 0,  1, 0,  0, 8'h00, 4, 5));
    vecs.push_back(mk(1, 8'h12, 0, 1, 0, 0,  1, 0,  0, 8'h00, 4, 5));
    vecs.push_back(mk(1, 8'h50, 1, 0, 0, 0,  1, 0,  0, 8'h00, 3, 5));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0,  0, 1,  0, 8'h40, 3, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0,  0, 1,  1, 8'h12, 3, 1));
    // opcode 12 is on the bus: jump to its low nibble
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1,  0, 1,  2, 8'h50, 3, 2));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0,  0, 1,  0, 8'h40, 3, 3));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0,  0, 1,  0, 8'h40, 3, 4));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0,  0, 1,  0, 8'h40, 3, 5));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0,  0, 1,  0, 8'h40, 3, 6));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0,  0, 1,  1, 8'h12, 3, 7));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 0,  0, 8'h00, 3, 8));

    // reset state
    step();
    step();
    check_outs("reset", 0, 0, 0, 8'h00, 0);
    check("reset instr_count", 32'(instr_count), 32'd0);
    reset = 1'b0;
    step();
    check("post-reset load_ready", 32'(lif.load_ready), 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].lv, vecs[i].ld, vecs[i].ll, vecs[i].r, vecs[i].w, vecs[i].s);
      step();
      check_outs($sformatf("row%0d", i), vecs[i].e_ready, vecs[i].e_running,
                 int'(vecs[i].e_pc), vecs[i].e_op, int'(vecs[i].e_plen));
      check($sformatf("row%0d instr_count", i), 32'(instr_count), 32'(vecs[i].e_icnt));
    end

    // reset clears prog_len; run on an empty program is ignored
    drive(0, 8'h00, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    check_outs("reset2", 0, 0, 0, 8'h00, 0);
    reset = 1'b0;
    step();
    check("reset2 load_ready", 32'(lif.load_ready), 32'd1);
    drive(0, 8'h00, 0, 1, 1, 0);
    step();
    check_outs("empty run", 1, 0, 0, 8'h00, 0);
    step();
    check("empty run state", 32'(dbg_state), 32'd0);

    // full-depth load without load_last ends itself after 16 bytes
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'hC0 + 8'(i), 0, 0, 0, 0);
      step();
      check_outs($sformatf("fill%0d", i), 1, 0, 0, 8'h00, (i == 15) ? 16 : 0);
    end
    drive(0, 8'h00, 0, 0, 0, 0);
    step();
    check("fill end state", 32'(dbg_state), 32'd0);

    drive(0, 8'h00, 0, 1, 1, 0);
    step();
    check_outs("full run0", 0, 1, 0, 8'hC0, 16);
    for (int k = 1; k < 16; k++) begin
      step();
      check_outs($sformatf("full run%0d", k), 0, 1, k, 8'hC0 + 8'(k), 16);
    end
    step();
    check_outs("full wrap", 0, 1, 0, 8'hC0, 16);
    for (int k = 1; k < 4; k++) begin
      step();
      check_outs($sformatf("pre-reset run%0d", k), 0, 1, k, 8'hC0 + 8'(k), 16);
    end

    // reset for one cycle at pc=3 while running
    reset = 1'b1;
    step();
    check_outs("mid-run reset", 0, 0, 0, 8'h00, 0);
    check("mid-run reset instr_count", 32'(instr_count), 32'd0);
    reset = 1'b0;
    drive(0, 8'h00, 0, 0, 0, 0);
    step();
    check_outs("after reset", 1, 0, 0, 8'h00, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
